// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the full-range BT.709 YCbCr to RGB converter.
// Coefficients are Q12 signed; widths sized so no intermediate can overflow.
package ycbcr_pkg;

    localparam int FRAC_BITS = 12;
    localparam int PROD_W    = 22;
    localparam int SUM_W     = 24;

    localparam logic signed [PROD_W-1:0] KRV = 22'sd6450;  // 1.5748
    localparam logic signed [PROD_W-1:0] KGU = 22'sd767;   // 0.1873
    localparam logic signed [PROD_W-1:0] KGV = 22'sd1917;  // 0.4681
    localparam logic signed [PROD_W-1:0] KBU = 22'sd7601;  // 1.8556

    localparam logic signed [SUM_W-1:0] ROUND = 24'sd2048;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pixel_t;

    typedef struct packed {
        logic signed [8:0] y;
        logic signed [8:0] cb;
        logic signed [8:0] cr;
    } centred_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] y_sh;
        logic signed [PROD_W-1:0] krv_cr;
        logic signed [PROD_W-1:0] kgu_cb;
        logic signed [PROD_W-1:0] kgv_cr;
        logic signed [PROD_W-1:0] kbu_cb;
    } prod_t;

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Video stream bundle: YCbCr pixels with syncs in, RGB pixels with aligned syncs out.
// The converter takes the slave view; the pixel source/sink takes the master view.
interface ycbcr2rgb_if;
    logic [23:0] ycbcr_i;
    logic        dv_i;
    logic        hs_i;
    logic        vs_i;
    logic [23:0] rgb_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        line_end_o;

    modport slave (
        input  ycbcr_i, dv_i, hs_i, vs_i,
        output rgb_o, dv_o, hs_o, vs_o, line_end_o
    );

    modport master (
        output ycbcr_i, dv_i, hs_i, vs_i,
        input  rgb_o, dv_o, hs_o, vs_o, line_end_o
    );
endinterface

// File: rtl/ycbcr_sat.sv
// Combinational clamp of a signed value to unsigned 8 bits; zero latency, no handshake.
module ycbcr_sat
    import ycbcr_pkg::*;
(
    input  logic signed [SUM_W-1:0] val_i,
    output logic        [7:0]       val_o
);

    always_comb begin
        val_o = val_i[7:0];
        if (val_i[SUM_W-1]) begin
            val_o = 8'h00;
        end else if (|val_i[SUM_W-2:8]) begin
            val_o = 8'hFF;
        end
    end

endmodule

// File: rtl/ycbcr2rgb.sv
// Full-range BT.709 YCbCr to RGB, 3-stage pipeline: 3 clocks latency, one pixel per clock.
// No backpressure: the stream is never stalled, syncs are delayed to stay aligned with rgb_o.
module ycbcr2rgb
    import ycbcr_pkg::*;
#(
    parameter int COLORDEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ycbcr2rgb_if.slave    vid
);

    if (COLORDEPTH != 8) begin : g_bad_depth
        $error("ycbcr2rgb: only COLORDEPTH=8 is supported");
    end

    pixel_t   px;
    centred_t s1_d, s1_q;
    prod_t    s2_d, s2_q;
    logic [23:0] rgb_d, rgb_q;
    logic [2:0]  dv_sr_d, dv_sr_q;
    logic [2:0]  hs_sr_d, hs_sr_q;
    logic [2:0]  vs_sr_d, vs_sr_q;
    logic        line_end_d, line_end_q;

    logic signed [SUM_W-1:0] r_sum, g_sum, b_sum;
    logic signed [SUM_W-1:0] r_shf, g_shf, b_shf;
    logic [7:0] r8, g8, b8;

    assign px = vid.ycbcr_i;

    // Blanking pixels enter as zero so idle output is black.
    always_comb begin
        s1_d = '0;
        if (vid.dv_i) begin
            s1_d.y  = $signed({1'b0, px.y});
            s1_d.cb = $signed({1'b0, px.cb}) - 9'sd128;
            s1_d.cr = $signed({1'b0, px.cr}) - 9'sd128;
        end
    end

    always_comb begin
        s2_d        = '0;
        s2_d.y_sh   = PROD_W'(s1_q.y) <<< FRAC_BITS;
        s2_d.krv_cr = KRV * PROD_W'(s1_q.cr);
        s2_d.kgu_cb = KGU * PROD_W'(s1_q.cb);
        s2_d.kgv_cr = KGV * PROD_W'(s1_q.cr);
        s2_d.kbu_cb = KBU * PROD_W'(s1_q.cb);
    end

    always_comb begin
        r_sum = SUM_W'(s2_q.y_sh) + SUM_W'(s2_q.krv_cr) + ROUND;
        g_sum = SUM_W'(s2_q.y_sh) - SUM_W'(s2_q.kgu_cb) - SUM_W'(s2_q.kgv_cr) + ROUND;
        b_sum = SUM_W'(s2_q.y_sh) + SUM_W'(s2_q.kbu_cb) + ROUND;
        r_shf = r_sum >>> FRAC_BITS;
        g_shf = g_sum >>> FRAC_BITS;
        b_shf = b_sum >>> FRAC_BITS;
    end

    ycbcr_sat u_sat_r (.val_i(r_shf), .val_o(r8));
    ycbcr_sat u_sat_g (.val_i(g_shf), .val_o(g8));
    ycbcr_sat u_sat_b (.val_i(b_shf), .val_o(b8));

    // line_end fires as dv_o falls, so it lands in the first blank output cycle.
    always_comb begin
        rgb_d      = {r8, g8, b8};
        dv_sr_d    = {dv_sr_q[1:0], vid.dv_i};
        hs_sr_d    = {hs_sr_q[1:0], vid.hs_i};
        vs_sr_d    = {vs_sr_q[1:0], vid.vs_i};
        line_end_d = dv_sr_q[2] & ~dv_sr_q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            rgb_q      <= '0;
            dv_sr_q    <= '0;
            hs_sr_q    <= '0;
            vs_sr_q    <= '0;
            line_end_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rgb_q      <= rgb_d;
            dv_sr_q    <= dv_sr_d;
            hs_sr_q    <= hs_sr_d;
            vs_sr_q    <= vs_sr_d;
            line_end_q <= line_end_d;
        end
    end

    assign vid.rgb_o      = rgb_q;
    assign vid.dv_o       = dv_sr_q[2];
    assign vid.hs_o       = hs_sr_q[2];
    assign vid.vs_o       = vs_sr_q[2];
    assign vid.line_end_o = line_end_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: directed pixels with hand-computed RGB, line_end timing and reset.
module tb_ycbcr2rgb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ycbcr2rgb_if vid();

    ycbcr2rgb #(.COLORDEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    int   le_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_dv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        checks++;
        failures++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, got, cyc);
    endtask

    // One input cycle; outputs for this pixel are due 3 clocks later.
    task automatic drive(input logic dv, input logic [23:0] pix, input logic [23:0] rgb_exp,
                         input logic hs, input logic vs);
        exp_t e;
        @(posedge clk);
        #1;
        vid.dv_i    = dv;
        vid.ycbcr_i = pix;
        vid.hs_i    = hs;
        vid.vs_i    = vs;
        if (dv) begin
            e.cyc = cyc + 3;
            e.rgb = rgb_exp;
            e.hs  = hs;
            e.vs  = vs;
            exp_q.push_back(e);
        end else if (prev_dv) begin
            le_q.push_back(cyc + 3);
        end
        prev_dv = dv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'hFF00FF, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rgb_o"}, vid.rgb_o, 0);
        chk({tag, "_dv_o"}, vid.dv_o, 0);
        chk({tag, "_hs_o"}, vid.hs_o, 0);
        chk({tag, "_vs_o"}, vid.vs_o, 0);
        chk({tag, "_line_end_o"}, vid.line_end_o, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (vid.dv_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    unexpected("dv_o_unexpected", vid.rgb_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("dv_o_cycle", cyc, e.cyc);
                    chk("rgb_o", vid.rgb_o, e.rgb);
                    chk("hs_o", vid.hs_o, e.hs);
                    chk("vs_o", vid.vs_o, e.vs);
                end
            end else begin
                chk("rgb_o_blank", vid.rgb_o, 0);
            end
            if (vid.line_end_o !== 1'b0) begin
                if (le_q.size() == 0) unexpected("line_end_unexpected", vid.line_end_o);
                else chk("line_end_cycle", cyc, le_q.pop_front());
            end
        end
    end

    initial begin
        // Inputs are live during reset so only the reset can hold outputs at zero.
        rst         = 1'b0;
        vid.dv_i    = 1'b1;
        vid.ycbcr_i = 24'h808080;
        vid.hs_i    = 1'b1;
        vid.vs_i    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset");
        vid.dv_i    = 1'b0;
        vid.ycbcr_i = 24'hFF00FF;
        vid.hs_i    = 1'b0;
        vid.vs_i    = 1'b0;
        rst         = 1'b1;

        idle(6);

        // Four-pixel line with syncs embedded, then blanking.
        drive(1'b1, 24'h808080, 24'h808080, 1'b0, 1'b1);
        drive(1'b1, 24'hFF80FF, 24'hFFC4FF, 1'b1, 1'b0);
        drive(1'b1, 24'h000080, 24'h001800, 1'b0, 1'b0);
        drive(1'b1, 24'h108080, 24'h101010, 1'b1, 1'b1);
        idle(6);

        // Single-pixel line.
        drive(1'b1, 24'h64C832, 24'h007BEA, 1'b0, 1'b0);
        idle(5);

        // dv_i toggling every cycle.
        drive(1'b1, 24'h3264B4, 24'h841F00, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 24'h808080, 24'h808080, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 24'hFF80FF, 24'hFFC4FF, 1'b0, 1'b1);
        idle(6);

        // Reset mid-line while outputs are active.
        drive(1'b1, 24'h808080, 24'h808080, 1'b0, 1'b0);
        drive(1'b1, 24'h64C832, 24'h007BEA, 1'b1, 1'b0);
        drive(1'b1, 24'h3264B4, 24'h841F00, 1'b0, 1'b1);
        drive(1'b1, 24'h000080, 24'h001800, 1'b0, 1'b0);
        drive(1'b1, 24'hFF80FF, 24'hFFC4FF, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_reset_dv_o", vid.dv_o, 1);
        rst         = 1'b0;
        vid.dv_i    = 1'b0;
        vid.hs_i    = 1'b0;
        vid.vs_i    = 1'b0;
        prev_dv     = 1'b0;
        exp_q.delete();
        le_q.delete();
        #1;
        check_all_zero("midline_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b1;

        idle(1);
        drive(1'b1, 24'h108080, 24'h101010, 1'b1, 1'b0);
        drive(1'b1, 24'h64C832, 24'h007BEA, 1'b0, 1'b1);
        idle(8);

        chk("pixels_drained", exp_q.size(), 0);
        chk("line_ends_drained", le_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
